hsv_color_tracker: RTL and testbench

//  Per-pixel colour classifier and object locator; sits downstream of the calibration averager.

---
 rtl/hsv_color_tracker_pkg.sv | 18 +
 rtl/hsv_color_tracker_rgb_to_hsv_pipe.sv | 84 ++++++++
 rtl/hsv_color_tracker.sv | 199 +++++++++++++++++++
 tb/tb_hsv_color_tracker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_color_tracker_pkg.sv
// Shared widths and hue-sector encoding for the HSV colour tracker and its
// RGB->HSV front end.
package hsv_color_tracker_pkg;

  localparam int PIX_W = 8;
  localparam int ROW_W = 13;
  localparam int HUE_W = 14;

  // Sector offsets as shift amounts: G-max adds 2*diff, B-max adds 4*diff.
  localparam int HUE_SH_G = 1;
  localparam int HUE_SH_B = 2;

  typedef enum logic {
    ST_ACC,
    ST_CLOSE
  } acc_state_e;

endpackage

// File: rtl/hsv_color_tracker_rgb_to_hsv_pipe.sv
// Two-stage RGB -> (H, diff, max) converter with a pass-through sideband,
// shared with the calibration path.
module rgb_to_hsv_pipe
  import hsv_color_tracker_pkg::*;
#(
  parameter int SB_W = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    vld_i,
  input  logic [PIX_W-1:0]        r_i,
  input  logic [PIX_W-1:0]        g_i,
  input  logic [PIX_W-1:0]        b_i,
  input  logic [SB_W-1:0]         sb_i,
  output logic                    vld_o,
  output logic signed [HUE_W-1:0] h_o,
  output logic [PIX_W-1:0]        diff_o,
  output logic [PIX_W-1:0]        max_o,
  output logic [SB_W-1:0]         sb_o
);

  logic                    vld_p1, vld_p2;
  logic [PIX_W-1:0]        r_p1, g_p1, b_p1;
  logic [SB_W-1:0]         sb_p1, sb_p2;
  logic [PIX_W-1:0]        max_c, min_c, diff_c;
  logic signed [HUE_W-1:0] r_s, g_s, b_s, d_s, h_c;
  logic [PIX_W-1:0]        diff_p2, max_p2;
  logic signed [HUE_W-1:0] h_p2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_i;
      vld_p2 <= vld_p1;
    end
  end

  // S1: register raw pixel
  always_ff @(posedge clk) begin
    r_p1  <= r_i;
    g_p1  <= g_i;
    b_p1  <= b_i;
    sb_p1 <= sb_i;
  end

  always_comb begin
    max_c = r_p1;
    min_c = r_p1;
    if (g_p1 > max_c) max_c = g_p1;
    if (b_p1 > max_c) max_c = b_p1;
    if (g_p1 < min_c) min_c = g_p1;
    if (b_p1 < min_c) min_c = b_p1;
    diff_c = max_c - min_c;
  end

  assign r_s = $signed({{(HUE_W-PIX_W){1'b0}}, r_p1});
  assign g_s = $signed({{(HUE_W-PIX_W){1'b0}}, g_p1});
  assign b_s = $signed({{(HUE_W-PIX_W){1'b0}}, b_p1});
  assign d_s = $signed({{(HUE_W-PIX_W){1'b0}}, diff_c});

  // Ties resolve R > G > B; red hue is left unwrapped around zero.
  always_comb begin
    if (r_p1 >= g_p1 && r_p1 >= b_p1) h_c = g_s - b_s;
    else if (g_p1 >= b_p1)            h_c = (b_s - r_s) + (d_s <<< HUE_SH_G);
    else                              h_c = (r_s - g_s) + (d_s <<< HUE_SH_B);
  end

  // S2: register hue, saturation proxy and value
  always_ff @(posedge clk) begin
    h_p2    <= h_c;
    diff_p2 <= diff_c;
    max_p2  <= max_c;
    sb_p2   <= sb_p1;
  end

  assign vld_o  = vld_p2;
  assign h_o    = h_p2;
  assign diff_o = diff_p2;
  assign max_o  = max_p2;
  assign sb_o   = sb_p2;

endmodule

// File: rtl/hsv_color_tracker.sv
// Per-pixel colour match against a latched calibration, with per-frame match
// count and bounding box reported on each frame_end.
module hsv_color_tracker
  import hsv_color_tracker_pkg::*;
#(
  parameter logic [HUE_W-1:0] H_TOL = 14'd24,
  parameter logic [PIX_W-1:0] S_MIN = 8'd32,
  parameter logic [PIX_W-1:0] V_MIN = 8'd40,
  parameter int               CNT_W = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pix_valid,
  input  logic [PIX_W-1:0]        raw_R,
  input  logic [PIX_W-1:0]        raw_G,
  input  logic [PIX_W-1:0]        raw_B,
  input  logic [ROW_W-1:0]        row,
  input  logic [ROW_W-1:0]        col,
  input  logic                    frame_end,
  input  logic                    cal_load,
  input  logic signed [HUE_W-1:0] cal_H,
  input  logic [PIX_W-1:0]        cal_S,
  input  logic [PIX_W-1:0]        cal_V,
  output logic                    mask_valid,
  output logic                    mask,
  output logic                    res_valid,
  output logic                    obj_found,
  output logic [CNT_W-1:0]        match_cnt,
  output logic [ROW_W-1:0]        bb_rmin,
  output logic [ROW_W-1:0]        bb_rmax,
  output logic [ROW_W-1:0]        bb_cmin,
  output logic [ROW_W-1:0]        bb_cmax
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [HUE_W:0] abs_h(input logic signed [HUE_W:0] x);
    return x[HUE_W] ? $unsigned(-x) : $unsigned(x);
  endfunction

  logic                    cal_ok_q;
  logic signed [HUE_W-1:0] cal_h_q;
  logic                    vld_p2;
  logic signed [HUE_W-1:0] h_p2;
  logic [PIX_W-1:0]        diff_p2, max_p2;
  logic [2*ROW_W-1:0]      sb_p2;
  logic                    fe_p1, fe_p2, fe_p3;
  logic                    mask_valid_q, mask_q;
  logic [ROW_W-1:0]        row_p3, col_p3;
  logic signed [HUE_W:0]   hdiff_c;
  logic                    match_c, hit_c;
  acc_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, mcnt_q, mcnt_d;
  logic [ROW_W-1:0]        rmin_q, rmin_d, rmax_q, rmax_d, cmin_q, cmin_d, cmax_q, cmax_d;
  logic [ROW_W-1:0]        brmin_q, brmin_d, brmax_q, brmax_d, bcmin_q, bcmin_d, bcmax_q, bcmax_d;
  logic                    obj_q, obj_d;
  logic                    unused_cal;

  // Match thresholds are fixed parameters; calibrated S/V are informational only.
  assign unused_cal = ^{cal_S, cal_V};

  always_ff @(posedge clk) begin
    if (!reset_n)      cal_ok_q <= 1'b0;
    else if (cal_load) cal_ok_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (cal_load) cal_h_q <= cal_H;
  end

  rgb_to_hsv_pipe #(.SB_W(2*ROW_W)) u_hsv (
    .clk    (clk),
    .reset_n(reset_n),
    .vld_i  (pix_valid),
    .r_i    (raw_R),
    .g_i    (raw_G),
    .b_i    (raw_B),
    .sb_i   ({row, col}),
    .vld_o  (vld_p2),
    .h_o    (h_p2),
    .diff_o (diff_p2),
    .max_o  (max_p2),
    .sb_o   (sb_p2)
  );

  assign hdiff_c = {h_p2[HUE_W-1], h_p2} - {cal_h_q[HUE_W-1], cal_h_q};
  assign match_c = cal_ok_q && (abs_h(hdiff_c) <= {1'b0, H_TOL}) &&
                   (diff_p2 >= S_MIN) && (max_p2 >= V_MIN);

  // S3: register mask and the frame_end that travelled alongside the pixel
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fe_p1        <= 1'b0;
      fe_p2        <= 1'b0;
      fe_p3        <= 1'b0;
      mask_valid_q <= 1'b0;
      mask_q       <= 1'b0;
    end else begin
      fe_p1        <= frame_end;
      fe_p2        <= fe_p1;
      fe_p3        <= fe_p2;
      mask_valid_q <= vld_p2;
      mask_q       <= vld_p2 & match_c;
    end
  end

  always_ff @(posedge clk) begin
    row_p3 <= sb_p2[2*ROW_W-1:ROW_W];
    col_p3 <= sb_p2[ROW_W-1:0];
  end

  assign hit_c = mask_valid_q & mask_q;

  // A zero count marks the first match of a frame; it never returns to zero by saturation.
  always_comb begin
    state_d = fe_p3 ? ST_CLOSE : ST_ACC;
    cnt_d   = cnt_q;
    rmin_d  = rmin_q;
    rmax_d  = rmax_q;
    cmin_d  = cmin_q;
    cmax_d  = cmax_q;
    obj_d   = obj_q;
    mcnt_d  = mcnt_q;
    brmin_d = brmin_q;
    brmax_d = brmax_q;
    bcmin_d = bcmin_q;
    bcmax_d = bcmax_q;
    if (hit_c) begin
      cnt_d = sat_inc(cnt_q);
      if (cnt_q == '0) begin
        rmin_d = row_p3;
        rmax_d = row_p3;
        cmin_d = col_p3;
        cmax_d = col_p3;
      end else begin
        rmin_d = (row_p3 < rmin_q) ? row_p3 : rmin_q;
        rmax_d = (row_p3 > rmax_q) ? row_p3 : rmax_q;
        cmin_d = (col_p3 < cmin_q) ? col_p3 : cmin_q;
        cmax_d = (col_p3 > cmax_q) ? col_p3 : cmax_q;
      end
    end
    if (fe_p3) begin
      obj_d   = (cnt_d != '0);
      mcnt_d  = cnt_d;
      brmin_d = rmin_d;
      brmax_d = rmax_d;
      bcmin_d = cmin_d;
      bcmax_d = cmax_d;
      cnt_d   = '0;
      rmin_d  = '0;
      rmax_d  = '0;
      cmin_d  = '0;
      cmax_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      rmin_q  <= '0;
      rmax_q  <= '0;
      cmin_q  <= '0;
      cmax_q  <= '0;
      obj_q   <= 1'b0;
      mcnt_q  <= '0;
      brmin_q <= '0;
      brmax_q <= '0;
      bcmin_q <= '0;
      bcmax_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rmin_q  <= rmin_d;
      rmax_q  <= rmax_d;
      cmin_q  <= cmin_d;
      cmax_q  <= cmax_d;
      obj_q   <= obj_d;
      mcnt_q  <= mcnt_d;
      brmin_q <= brmin_d;
      brmax_q <= brmax_d;
      bcmin_q <= bcmin_d;
      bcmax_q <= bcmax_d;
    end
  end

  assign mask_valid = mask_valid_q;
  assign mask       = mask_q;
  assign res_valid  = (state_q == ST_CLOSE);
  assign obj_found  = obj_q;
  assign match_cnt  = mcnt_q;
  assign bb_rmin    = brmin_q;
  assign bb_rmax    = brmax_q;
  assign bb_cmin    = bcmin_q;
  assign bb_cmax    = bcmax_q;

endmodule

// File: tb/tb_hsv_color_tracker.sv
// Bench for hsv_color_tracker: directed and random pixel streams checked
// against a per-pixel / per-frame reference model.
module tb_hsv_color_tracker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_valid = 1'b0, frame_end = 1'b0, cal_load = 1'b0;
  logic [7:0]  raw_R = '0, raw_G = '0, raw_B = '0, cal_S = '0, cal_V = '0;
  logic [12:0] row = '0, col = '0;
  logic [13:0] cal_H = '0;
  logic        mask_valid, mask, res_valid, obj_found;
  logic [19:0] match_cnt;
  logic [12:0] bb_rmin, bb_rmax, bb_cmin, bb_cmax;

  always #5 clk = ~clk;

  hsv_color_tracker dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid),
    .raw_R(raw_R), .raw_G(raw_G), .raw_B(raw_B), .row(row), .col(col),
    .frame_end(frame_end), .cal_load(cal_load), .cal_H(cal_H), .cal_S(cal_S), .cal_V(cal_V),
    .mask_valid(mask_valid), .mask(mask), .res_valid(res_valid), .obj_found(obj_found),
    .match_cnt(match_cnt), .bb_rmin(bb_rmin), .bb_rmax(bb_rmax), .bb_cmin(bb_cmin), .bb_cmax(bb_cmax)
  );

  typedef struct { bit v; bit m; } pe_t;
  typedef struct { int cnt; int rmin; int rmax; int cmin; int cmax; int due; } fr_t;

  int  vectors = 0, miscompares = 0, cyc = 0;
  pe_t pipe_q[$];
  fr_t fr_q[$];
  bit  m_cal_ok = 0;
  int  m_cal_h = 0;
  int  a_cnt = 0, a_rmin = 0, a_rmax = 0, a_cmin = 0, a_cmax = 0;
  int  l_cnt = 0;

  function automatic int hue(input int r, input int g, input int b);
    int mx, mn, d;
    mx = (r >= g && r >= b) ? r : (g >= b ? g : b);
    mn = (r <= g && r <= b) ? r : (g <= b ? g : b);
    d  = mx - mn;
    if (r == mx)      return g - b;
    else if (g == mx) return (b - r) + 2 * d;
    else              return (r - g) + 4 * d;
  endfunction

  function automatic bit ref_match(input int r, input int g, input int b);
    int mx, mn, dh;
    mx = (r >= g && r >= b) ? r : (g >= b ? g : b);
    mn = (r <= g && r <= b) ? r : (g <= b ? g : b);
    dh = hue(r, g, b) - m_cal_h;
    if (dh < 0) dh = -dh;
    return m_cal_ok && (dh <= 24) && (mx - mn >= 32) && (mx >= 40);
  endfunction

  function automatic int clamp8(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    pe_t e;
    fr_t f;
    if (pipe_q.size() == 3) begin
      e = pipe_q.pop_front();
      chk("mask_valid", {31'd0, mask_valid}, {31'd0, e.v});
      chk("mask", {31'd0, mask}, {31'd0, e.m});
    end
    if (res_valid === 1'b1) begin
      if (fr_q.size() == 0) chk("res_valid_spurious", {31'd0, res_valid}, 32'd0);
      else begin
        f = fr_q.pop_front();
        chk("res_latency", cyc, f.due);
        chk("obj_found", {31'd0, obj_found}, (f.cnt != 0) ? 32'd1 : 32'd0);
        chk("match_cnt", {12'd0, match_cnt}, f.cnt);
        chk("bb_rmin", {19'd0, bb_rmin}, f.rmin);
        chk("bb_rmax", {19'd0, bb_rmax}, f.rmax);
        chk("bb_cmin", {19'd0, bb_cmin}, f.cmin);
        chk("bb_cmax", {19'd0, bb_cmax}, f.cmax);
        l_cnt = f.cnt;
      end
    end else begin
      chk("hold_cnt", {12'd0, match_cnt}, l_cnt);
      chk("hold_obj", {31'd0, obj_found}, (l_cnt != 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic cycle(input bit v, input int r, input int g, input int b,
                       input int rw, input int cl, input bit fe);
    pe_t e;
    fr_t f;
    @(negedge clk);
    pix_valid = v; raw_R = 8'(r); raw_G = 8'(g); raw_B = 8'(b);
    row = 13'(rw); col = 13'(cl); frame_end = fe;
    e.v = v;
    e.m = v && ref_match(r, g, b);
    if (e.m) begin
      if (a_cnt == 0) begin
        a_rmin = rw; a_rmax = rw; a_cmin = cl; a_cmax = cl;
      end else begin
        if (rw < a_rmin) a_rmin = rw;
        if (rw > a_rmax) a_rmax = rw;
        if (cl < a_cmin) a_cmin = cl;
        if (cl > a_cmax) a_cmax = cl;
      end
      a_cnt++;
    end
    if (fe) begin
      f.cnt = a_cnt; f.rmin = a_rmin; f.rmax = a_rmax; f.cmin = a_cmin; f.cmax = a_cmax;
      f.due = cyc + 4;
      fr_q.push_back(f);
      a_cnt = 0; a_rmin = 0; a_rmax = 0; a_cmin = 0; a_cmax = 0;
    end
    pipe_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    cal_load = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle(6);
    chk("res_pending", fr_q.size(), 32'd0);
  endtask

  task automatic cal(input int h);
    idle(3);
    cal_H = 14'(h); cal_S = 8'd200; cal_V = 8'd200; cal_load = 1'b1;
    idle(1);
    m_cal_ok = 1; m_cal_h = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; pix_valid = 1'b0; frame_end = 1'b0; cal_load = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rst_mask_valid", {31'd0, mask_valid}, 32'd0);
    chk("rst_mask", {31'd0, mask}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_obj_found", {31'd0, obj_found}, 32'd0);
    chk("rst_match_cnt", {12'd0, match_cnt}, 32'd0);
    chk("rst_bb", {6'd0, bb_rmin, bb_rmax[0], bb_cmin[0], bb_cmax[0]}, 32'd0);
    chk("rst_bb_hi", {7'd0, bb_rmax[12:1], bb_cmin[12:1], 1'b0} | {19'd0, bb_cmax}, 32'd0);
    reset_n = 1'b1;
    pipe_q.delete(); fr_q.delete();
    m_cal_ok = 0; a_cnt = 0; a_rmin = 0; a_rmax = 0; a_cmin = 0; a_cmax = 0; l_cnt = 0;
  endtask

  task automatic rand_frame(input int n, input int sr, input int sg, input int sb, input bit fe_last);
    int r, g, b;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        r = clamp8(sr + int'($urandom_range(0, 30)) - 15);
        g = clamp8(sg + int'($urandom_range(0, 30)) - 15);
        b = clamp8(sb + int'($urandom_range(0, 30)) - 15);
      end else begin
        r = int'($urandom_range(0, 255));
        g = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
      end
      cycle(1, r, g, b, int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)),
            fe_last && (i == n - 1));
    end
    if (!fe_last) cycle(0, 0, 0, 0, 0, 0, 1);
    drain();
  endtask

  initial begin
    int sr, sg, sb;
    do_reset();

    // No calibration: red pixels never match.
    for (int i = 0; i < 5; i++) cycle(1, 200, 0, 0, i, i, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    drain();

    // Single matching red pixel.
    cal(0);
    cycle(1, 200, 0, 0, 10, 20, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    drain();

    // Hue tolerance and S/V thresholds.
    cycle(1, 200, 20, 0, 1, 1, 0);
    cycle(1, 200, 30, 0, 2, 2, 0);
    cycle(1, 40, 30, 30, 3, 3, 0);
    cycle(1, 30, 0, 0, 4, 4, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    drain();

    // Bounding box over three matches, then an empty frame.
    cycle(1, 200, 0, 0, 5, 7, 0);
    cycle(1, 200, 0, 0, 50, 3, 0);
    cycle(1, 200, 0, 0, 12, 90, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    drain();
    cycle(0, 0, 0, 0, 0, 0, 1);
    drain();

    // frame_end alongside the last matching pixel.
    cycle(1, 200, 10, 0, 100, 200, 0);
    cycle(1, 220, 0, 5, 300, 40, 1);
    drain();

    // Random frames, each against a calibration taken from a random seed colour.
    for (int k = 0; k < 6; k++) begin
      sr = int'($urandom_range(0, 255));
      sg = int'($urandom_range(0, 255));
      sb = int'($urandom_range(0, 255));
      cal(hue(sr, sg, sb));
      rand_frame(40, sr, sg, sb, k[0]);
    end

    // Recalibration mid-frame (stream idle around the load).
    cycle(1, 200, 0, 0, 7, 7, 0);
    cal(hue(0, 200, 0));
    cycle(1, 0, 200, 0, 9, 1, 0);
    cycle(1, 200, 0, 0, 9, 2, 1);
    drain();

    // Reset mid-frame clears results and calibration.
    cal(0);
    cycle(1, 200, 0, 0, 1, 1, 0);
    cycle(1, 200, 0, 0, 2, 2, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 200, 0, 0, i, i, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
